// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner.
// Holds the active-low segment patterns ({g,f,e,d,c,b,a}) and the scan FSM state encoding.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
// Ports:
//   code - 4-bit digit code
//   seg  - active-low pattern {g,f,e,d,c,b,a}; codes 10..15 show a dash
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner.
// Snapshots NUM_DIGITS BCD digits plus decimal points into shadow registers and scans them,
// driving each digit for SCAN_DIV cycles with a BLANK_CYCLES all-off gap before each digit.
// Ports:
//   clk, rst  - clock; asynchronous active-high reset
//   bcd_in    - digit i in bits [4i+3:4i], digit 0 least significant
//   dp_in     - decimal-point request per digit
//   latch     - capture bcd_in/dp_in into the shadow registers
//   blank_lz  - enable leading-zero blanking (live, not shadowed)
//   seg, dp_n - active-low segments {g,f,e,d,c,b,a} and decimal point
//   an        - active-low digit enables
//   digit_idx - digit currently selected
module bcd_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    latch,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [BW-1:0]           blank_q, blank_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;

  logic [NUM_DIGITS-1:0]   zero_above;
  logic                    lz_run;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_zero_above;
  logic [6:0]              dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
    end else if (latch) begin
      shadow_bcd_q <= bcd_in;
      shadow_dp_q  <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      presc_q <= '0;
      blank_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    blank_d = blank_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_BLANK: begin
        if (blank_q == BW'(BLANK_CYCLES - 1)) begin
          state_d = ST_ON;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_ON: begin
        if (presc_q == PW'(SCAN_DIV - 1)) begin
          state_d = ST_BLANK;
          presc_d = '0;
          idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // zero_above[i] is set when shadow digits NUM_DIGITS-1 down to i are all zero; a non-BCD
  // code is nonzero so it stops the run.
  always_comb begin
    zero_above = '0;
    lz_run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run        = lz_run & (shadow_bcd_q[4*i +: 4] == 4'd0);
      zero_above[i] = lz_run;
    end
  end

  // Mux driven only by registered state so the outputs never see a raw input digit.
  always_comb begin
    cur_code       = '0;
    cur_dp         = 1'b0;
    cur_zero_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code       = shadow_bcd_q[4*i +: 4];
        cur_dp         = shadow_dp_q[i];
        cur_zero_above = zero_above[i];
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    an   = '1;
    seg  = SEG_OFF;
    dp_n = 1'b1;
    if (state_q == ST_ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an[i] = (idx_q != IW'(i));
      end
      // Digit 0 is never blanked; the anode stays on for a blanked digit so its dp still shows.
      seg  = (blank_lz && (idx_q != '0) && cur_zero_above) ? SEG_OFF : dec_seg;
      dp_n = ~cur_dp;
    end
  end

  assign digit_idx = idx_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2.
// Each digit slot is 6 cycles: 2 blank then 4 lit; a frame is 24 cycles.
module tb_bcd_seg_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SO = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        latch;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int n_vec = 0;
  int n_bad = 0;

  bcd_seg_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .latch     (latch),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp_n      (dp_n),
    .an        (an),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  // Advance one clock; latch is a single-edge pulse.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    latch = 1'b0;
  endtask

  // Reset, then release with a latch request pending for the first edge.
  task automatic restart(input logic [15:0] b, input logic [3:0] d);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bcd_in   = b;
    dp_in    = d;
    latch    = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    latch    = 1'b0;
    bcd_in   = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({an, seg, dp_n, digit_idx} !== {4'hF, SO, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_hold: an=%b seg=%b dp_n=%b idx=%0d, want 1111 1111111 1 0",
               an, seg, dp_n, digit_idx);
    end
    rst = 1'b0;
    repeat (3) step();
    n_vec++;
    if ({an, seg} !== {4'b1110, S0}) begin
      n_bad++;
      $display("FAIL reset_first_on: an=%b seg=%b, want 1110 %b", an, seg, S0);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({an, seg, dp_n, digit_idx} !== {4'hF, SO, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_async: an=%b seg=%b dp_n=%b idx=%0d, want 1111 1111111 1 0",
               an, seg, dp_n, digit_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] ea;
      logic [6:0] es;
      ea = (k < 2) ? 4'hF : 4'b1110;
      es = (k < 2) ? SO : S0;
      n_vec++;
      if ({an, seg, dp_n, digit_idx} !== {ea, es, 1'b1, 2'd0}) begin
        n_bad++;
        $display("FAIL reset_release k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b 1 0",
                 k, an, seg, dp_n, digit_idx, ea, es);
      end
      step();
    end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg = '{S4, S3, S2, S1};
    restart(16'h1234, 4'h0);
    blank_lz = 1'b0;
    for (int k = 0; k < 30; k++) begin
      int sl;
      logic [3:0] ea;
      logic [6:0] es;
      sl = (k / 6) % 4;
      if (k % 6 < 2) begin
        ea = 4'hF;
        es = SO;
      end else begin
        ea = ~(4'b0001 << sl);
        es = exp_seg[sl];
      end
      n_vec++;
      if ({an, seg, dp_n, digit_idx} !== {ea, es, 1'b1, 2'(sl)}) begin
        n_bad++;
        $display("FAIL scan k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b 1 %0d",
                 k, an, seg, dp_n, digit_idx, ea, es, sl);
      end
      step();
    end
  endtask

  task automatic test_leading_zeros();
    logic [6:0] exp_seg [4];
    restart(16'h0070, 4'h0);
    for (int pass = 0; pass < 2; pass++) begin
      blank_lz = (pass == 0);
      if (pass == 0) exp_seg = '{S0, S7, SO, SO};
      else           exp_seg = '{S0, S7, S0, S0};
      for (int k = 0; k < 24; k++) begin
        int sl;
        logic [3:0] ea;
        logic [6:0] es;
        sl = k / 6;
        ea = (k % 6 < 2) ? 4'hF : ~(4'b0001 << sl);
        es = (k % 6 < 2) ? SO : exp_seg[sl];
        n_vec++;
        if ({an, seg, dp_n, digit_idx} !== {ea, es, 1'b1, 2'(sl)}) begin
          n_bad++;
          $display("FAIL lead_zero lz=%0d k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b 1 %0d",
                   blank_lz, k, an, seg, dp_n, digit_idx, ea, es, sl);
        end
        step();
      end
    end
  endtask

  task automatic test_invalid_code();
    logic [6:0] exp_seg [4];
    for (int pass = 0; pass < 2; pass++) begin
      restart((pass == 0) ? 16'h00A0 : 16'h0000, 4'h0);
      blank_lz = 1'b1;
      if (pass == 0) exp_seg = '{S0, SD, SO, SO};
      else           exp_seg = '{S0, SO, SO, SO};
      for (int k = 0; k < 24; k++) begin
        int sl;
        logic [3:0] ea;
        logic [6:0] es;
        sl = k / 6;
        ea = (k % 6 < 2) ? 4'hF : ~(4'b0001 << sl);
        es = (k % 6 < 2) ? SO : exp_seg[sl];
        n_vec++;
        if ({an, seg, dp_n, digit_idx} !== {ea, es, 1'b1, 2'(sl)}) begin
          n_bad++;
          $display("FAIL invalid pass=%0d k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b 1 %0d",
                   pass, k, an, seg, dp_n, digit_idx, ea, es, sl);
        end
        step();
      end
    end
  endtask

  task automatic test_decimal_point();
    logic [6:0] exp_seg [4];
    exp_seg = '{S0, SO, SO, SO};
    restart(16'h0000, 4'b0100);
    blank_lz = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int sl;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      sl = k / 6;
      ea = (k % 6 < 2) ? 4'hF : ~(4'b0001 << sl);
      es = (k % 6 < 2) ? SO : exp_seg[sl];
      ed = !((k % 6 >= 2) && (sl == 2));
      n_vec++;
      if ({an, seg, dp_n, digit_idx} !== {ea, es, ed, 2'(sl)}) begin
        n_bad++;
        $display("FAIL dp k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b %b %0d",
                 k, an, seg, dp_n, digit_idx, ea, es, ed, sl);
      end
      step();
    end
  endtask

  task automatic test_mid_events();
    logic [6:0] exp_seg [4];
    exp_seg = '{S4, S3, S2, S1};
    restart(16'h1234, 4'h0);
    blank_lz = 1'b0;
    for (int k = 0; k < 16; k++) begin
      int sl;
      logic [3:0] ea;
      logic [6:0] es;
      sl = k / 6;
      ea = (k % 6 < 2) ? 4'hF : ~(4'b0001 << sl);
      es = (k % 6 < 2) ? SO : ((k >= 10) ? S9 : exp_seg[sl]);
      n_vec++;
      if ({an, seg, dp_n, digit_idx} !== {ea, es, 1'b1, 2'(sl)}) begin
        n_bad++;
        $display("FAIL mid_latch k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b 1 %0d",
                 k, an, seg, dp_n, digit_idx, ea, es, sl);
      end
      if (k == 9) begin
        bcd_in = 16'h9999;
        latch  = 1'b1;
      end
      if (k < 15) step();
    end
    // Now in the second lit cycle of digit 2.
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({an, seg, dp_n, digit_idx} !== {4'hF, SO, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: an=%b seg=%b dp_n=%b idx=%0d, want 1111 1111111 1 0",
               an, seg, dp_n, digit_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      int sl;
      logic [3:0] ea;
      logic [6:0] es;
      sl = k / 6;
      ea = (k % 6 < 2) ? 4'hF : ~(4'b0001 << sl);
      es = (k % 6 < 2) ? SO : S0;
      n_vec++;
      if ({an, seg, dp_n, digit_idx} !== {ea, es, 1'b1, 2'(sl)}) begin
        n_bad++;
        $display("FAIL post_reset k=%0d: an=%b seg=%b dp_n=%b idx=%0d, want %b %b 1 %0d",
                 k, an, seg, dp_n, digit_idx, ea, es, sl);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zeros();
    test_invalid_code();
    test_decimal_point();
    test_mid_events();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
Downstream display stage for the decade counters. Captures a snapshot of NUM_DIGITS BCD digits (one per mod-10 counter) plus decimal points and drives a multiplexed, common-anode seven-segment display. It scans the digits with a programmable refresh period and inserts an anti-ghosting blank gap between digits. It also blanks leading zeros and shows a dash for non-BCD codes.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 100000, clk cycles each digit is driven (>=2)
BLANK_CYCLES, 16, clk cycles all anodes are off between digits (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
bcd_in  input  4*NUM_DIGITS  digit i in bits [4i+3:4i]; digit 0 is least significant
dp_in  input  NUM_DIGITS  decimal-point request per digit
latch  input  1  when 1, capture bcd_in/dp_in into shadow registers
blank_lz  input  1  enables leading-zero blanking
seg  output  7  {g,f,e,d,c,b,a}, active-low
dp_n  output  1  decimal point, active-low
an  output  NUM_DIGITS  digit enables, active-low, one-hot-low or all high
digit_idx  output  max(1,clog2(NUM_DIGITS))  digit currently selected

Behaviour:
- Clock and reset: one clock clk. rst is asynchronous and active-high.
- Reset values: shadow digits=0, shadow dp=0, state=BLANK, digit_idx=0, prescaler=0, blank counter=0. Outputs: an=all 1, seg=7'h7F, dp_n=1.
- Shadow capture: latch=1 at an edge loads bcd_in and dp_in. The displayed value changes the next cycle, even mid-digit. No tearing: the display uses only the shadow registers.
- FSM states:
  - BLANK: an all 1, seg=7'h7F, dp_n=1. The blank counter counts 0..BLANK_CYCLES-1. At terminal count the FSM goes to ON and clears the counter.
  - ON: an[digit_idx]=0, others 1. The prescaler counts 0..SCAN_DIV-1. At terminal count: digit_idx increments (NUM_DIGITS-1 wraps to 0), the prescaler clears, and the FSM goes to BLANK.
- Timing:
  - Digit period = SCAN_DIV+BLANK_CYCLES cycles. Frame = NUM_DIGITS times that.
  - After rst release, the first BLANK_CYCLES cycles are blank, then digit 0 is driven.
- Output decode: outputs are a pure combinational decode of registered state, digit_idx and shadow, with no extra latency. The decoder must not use unregistered inputs.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 show a dash: 0111111.
- Leading-zero blank: with blank_lz=1, digit i>0 is blanked (seg=7'h7F, an still asserted) if shadow digits NUM_DIGITS-1 down to i are all 0. Digit 0 is never blanked. A non-BCD code counts as nonzero.
- Decimal point: dp_n=0 iff state=ON and shadow dp[digit_idx]=1. This holds even when that digit is zero-blanked.
- blank_lz is sampled combinationally and is not shadowed.
- Reset mid-operation: everything returns to reset values immediately (async), including the shadow registers.

Decomposition:
- Package seg_pkg holds:
  - the segment code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - the state encoding ST_BLANK/ST_ON
- One natural combinational sub-module: bcd_to_seg (4-bit code in, 7-bit active-low pattern out, dash for 10..15).
- Prescaler, blank counter, FSM, shadow registers and leading-zero logic stay in bcd_seg_scanner.

Test Plan:
All tests use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2.
1. Reset: assert rst mid-cycle -> an=1111, seg=7F, dp_n=1, digit_idx=0 without a clock edge. After release: 2 blank cycles, then an=1110, seg=1000000 for 4 cycles.
2. Scan: latch bcd_in=16'h1234, blank_lz=0 -> sequence over 4 digit slots:
   - an=1110, seg=0011001 ("4")
   - an=1101, seg=0110000 ("3")
   - an=1011, seg=0100100 ("2")
   - an=0111, seg=1111001 ("1")
   - then wrap to 1110.
   - Each slot is 4 ON cycles preceded by 2 cycles with an=1111; frame = 24 cycles.
3. Leading zeros: bcd_in=16'h0070, blank_lz=1:
   - digits 3 and 2: seg=7F with an asserted
   - digit 1: 1111000
   - digit 0: 1000000
   - Repeat with blank_lz=0 -> digit 3 shows 1000000.
4. Invalid code: bcd_in=16'h00A0, blank_lz=1 -> digit 1 shows 0111111, and digit 2 is blanked. bcd_in=16'h0000 -> only digit 0 lit, showing 1000000.
5. Decimal point: dp_in=4'b0100 latched -> dp_n=0 only during ON with digit_idx=2; dp_n=1 during all BLANK cycles. With bcd_in=0 and blank_lz=1, digit 2 shows seg=7F and dp_n=0.
6. Mid-operation events:
   - latch new value 16'h9999 during digit 1 ON -> seg becomes 0010000 on the next cycle with no change to the slot timing.
   - rst asserted during digit 2 ON -> immediate reset values, and the shadow reads 0 after release.
